// File: rtl/memory_loader.sv
// Byte-stream loader for the program memory: accepts bytes over valid/ready and
// writes them to consecutive addresses on the shared bus while holding the CPU halted.
module memory_loader #(
    parameter int                    ADDR_WIDTH = 8,
    parameter int                    DATA_WIDTH = 8,
    parameter logic [ADDR_WIDTH-1:0] START_ADDR = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  mem_ie,
    inout  wire  [DATA_WIDTH-1:0] bus,
    output logic                  cpu_halt,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_WRITE,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] TOP_ADDR = '1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH + 1)'(1);

    state_t                  state, state_nxt;
    logic [ADDR_WIDTH-1:0]   addr_nxt;
    logic [ADDR_WIDTH:0]     count_nxt;
    logic [DATA_WIDTH-1:0]   data_q, data_nxt;
    logic                    last_q, last_nxt;
    logic                    drive_en;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt = state;
        addr_nxt  = mem_address;
        count_nxt = count;
        data_nxt  = data_q;
        last_nxt  = last_q;
        unique case (state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_nxt = S_WAIT;
                    addr_nxt  = START_ADDR;
                    count_nxt = '0;
                end
            end
            S_WAIT: begin
                if (in_valid && in_ready) begin
                    data_nxt  = in_data;
                    last_nxt  = in_last;
                    state_nxt = S_WRITE;
                end
            end
            S_WRITE: begin
                count_nxt = count + CNT_ONE;
                // The address never wraps: the top address either finishes or overflows.
                if (last_q) begin
                    state_nxt = S_DONE;
                end else if (mem_address == TOP_ADDR) begin
                    state_nxt = S_ERROR;
                end else begin
                    addr_nxt  = mem_address + ADDR_ONE;
                    state_nxt = S_WAIT;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they change only on the clock edge.
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            mem_address <= START_ADDR;
            count       <= '0;
            data_q      <= '0;
            last_q      <= 1'b0;
            in_ready    <= 1'b0;
            mem_ie      <= 1'b0;
            drive_en    <= 1'b0;
            cpu_halt    <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
        end else begin
            state       <= state_nxt;
            mem_address <= addr_nxt;
            count       <= count_nxt;
            data_q      <= data_nxt;
            last_q      <= last_nxt;
            in_ready    <= (state_nxt == S_WAIT);
            mem_ie      <= (state_nxt == S_WRITE);
            drive_en    <= (state_nxt == S_WRITE);
            cpu_halt    <= (state_nxt == S_WAIT) || (state_nxt == S_WRITE) || (state_nxt == S_ERROR);
            done        <= (state_nxt == S_DONE);
            error       <= (state_nxt == S_ERROR);
        end
    end

    assign bus = drive_en ? data_q : 'z;

endmodule

// File: tb/tb_memory_loader.sv
// Self-checking bench for memory_loader: table of load scenarios plus random loads,
// checked cycle by cycle against a byte-stream model and a negedge-sampled memory.
module tb_memory_loader;

    typedef logic [7:0] byte_q_t[$];

    typedef struct {
        int n;          // bytes offered
        int last_idx;   // index carrying in_last, -1 for none
        int min_gap;
        int max_gap;
        int exp_count;
        bit exp_done;
        bit exp_error;
    } scen_t;

    logic       clk, rst, start, in_valid, in_last;
    logic [7:0] in_data;
    logic       in_ready, mem_ie, cpu_halt, done, error;
    logic [7:0] mem_address;
    logic [8:0] count;
    wire  [7:0] bus;

    logic [7:0] mem [256];
    logic       mem_init;

    int n_cmp = 0;
    int n_bad = 0;

    // Byte-stream model state
    int         m_written;
    bit         m_done, m_err;
    logic [7:0] m_exp [256];

    memory_loader #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .START_ADDR(8'h00)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .mem_address(mem_address),
        .mem_ie     (mem_ie),
        .bus        (bus),
        .cpu_halt   (cpu_halt),
        .done       (done),
        .error      (error),
        .count      (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Program memory: samples the bus on the falling edge when enabled.
    always @(negedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'h5A;
        end else if (mem_ie) begin
            mem[mem_address] <= bus;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_mem();
        mem_init = 1'b1;
        @(negedge clk);
        #1;
        mem_init = 1'b0;
        for (int i = 0; i < 256; i++) m_exp[i] = 8'(i) ^ 8'h5A;
    endtask

    task automatic arm();
        in_valid = 1'b0;
        start    = 1'b1;
        step();
        start     = 1'b0;
        m_written = 0;
        m_done    = 1'b0;
        m_err     = 1'b0;
        check("arm_ready", in_ready, 1);
        check("arm_count", count, 0);
        check("arm_done", done, 0);
        check("arm_error", error, 0);
        check("arm_halt", cpu_halt, 1);
        check("arm_addr", mem_address, 0);
    endtask

    // Offers bytes with random gaps and checks every cycle against the model.
    task automatic send(input byte_q_t data, input int last_idx, input int min_gap, input int max_gap);
        int         idx = 0;
        int         gap = 0;
        int         budget = 0;
        bit         fire, cur_last;
        logic [7:0] cur_byte;
        while (budget < 3000) begin
            if (idx < data.size() && gap == 0) begin
                in_valid = 1'b1;
                in_data  = data[idx];
                in_last  = (idx == last_idx);
            end else begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                in_last  = 1'($urandom);
            end
            fire     = in_valid && in_ready;
            cur_byte = in_data;
            cur_last = in_last;
            step();
            budget++;
            check("mem_ie", mem_ie, fire);
            check("in_ready", in_ready, !fire && !(m_done || m_err));
            check("count", count, m_written);
            check("done", done, m_done);
            check("error", error, m_err);
            check("cpu_halt", cpu_halt, !m_done);
            if (fire) begin
                check("wr_addr", mem_address, m_written);
                check("wr_bus", bus, cur_byte);
                m_exp[m_written] = cur_byte;
                m_written++;
                if (cur_last) m_done = 1'b1;
                else if (m_written == 256) m_err = 1'b1;
                idx++;
                gap = $urandom_range(max_gap, min_gap);
            end else begin
                if (gap > 0) gap--;
                if (idx == data.size() || m_done || m_err) break;
            end
        end
        if (budget >= 3000) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: got %0d bytes expected %0d", idx, data.size());
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic check_mem(input string name);
        for (int i = 0; i < 256; i++) check(name, {mem[i], 8'(i)}, {m_exp[i], 8'(i)});
    endtask

    task automatic end_check(input int exp_count, input bit exp_done, input bit exp_error);
        check("end_count", count, exp_count);
        check("end_done", done, exp_done);
        check("end_error", error, exp_error);
        check("end_halt", cpu_halt, !exp_done);
        check("end_ready", in_ready, 0);
        check("end_mem_ie", mem_ie, 0);
        check("end_addr", mem_address, exp_count - 1);
        check_mem("mem");
    endtask

    scen_t   tbl [7];
    byte_q_t q;

    initial begin
        rst      = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 8'h00;
        mem_init = 1'b0;

        tbl[0] = '{3,   2,  0, 0, 3,   1'b1, 1'b0};
        tbl[1] = '{4,   3,  5, 5, 4,   1'b1, 1'b0};
        tbl[2] = '{256, 255, 0, 0, 256, 1'b1, 1'b0};
        tbl[3] = '{257, -1, 0, 0, 256, 1'b0, 1'b1};
        tbl[4] = '{1,   0,  0, 2, 1,   1'b1, 1'b0};
        tbl[5] = '{40,  39, 0, 3, 40,  1'b1, 1'b0};
        tbl[6] = '{10,  4,  0, 1, 5,   1'b1, 1'b0};

        #12;
        check("rst_ready", in_ready, 0);
        check("rst_mem_ie", mem_ie, 0);
        check("rst_halt", cpu_halt, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_count", count, 0);
        check("rst_addr", mem_address, 0);
        rst = 1'b1;
        step();
        check("idle_ready", in_ready, 0);

        for (int s = 0; s < 7; s++) begin
            fill_mem();
            q.delete();
            if (s == 0) q = '{8'hA1, 8'hB2, 8'hC3};
            else for (int i = 0; i < tbl[s].n; i++) q.push_back(8'($urandom));
            arm();
            send(q, tbl[s].last_idx, tbl[s].min_gap, tbl[s].max_gap);
            end_check(tbl[s].exp_count, tbl[s].exp_done, tbl[s].exp_error);
        end

        for (int r = 0; r < 4; r++) begin
            int n, last, ec;
            n    = $urandom_range(256, 1);
            last = $urandom_range(n - 1, 0);
            if (r == 3) begin
                n    = $urandom_range(300, 257);
                last = -1;
            end
            ec = (last >= 0 && last < 256) ? last + 1 : 256;
            fill_mem();
            q.delete();
            for (int i = 0; i < n; i++) q.push_back(8'($urandom));
            arm();
            send(q, last, 0, 3);
            end_check(ec, (last >= 0 && last < 256), !(last >= 0 && last < 256));
        end

        // start pulsed while waiting must not restart address or count
        fill_mem();
        arm();
        q = '{8'h3C, 8'h4D};
        send(q, -1, 0, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        check("wait_start_count", count, 2);
        check("wait_start_addr", mem_address, 2);
        check("wait_start_ready", in_ready, 1);
        check("wait_start_halt", cpu_halt, 1);
        q = '{8'h5E};
        send(q, 0, 0, 0);
        end_check(3, 1'b1, 1'b0);

        // reset during a write: second byte must not reach memory
        fill_mem();
        arm();
        q = '{8'h99};
        send(q, -1, 0, 0);
        in_valid = 1'b1;
        in_data  = 8'h77;
        in_last  = 1'b0;
        step();
        in_valid = 1'b0;
        check("pre_rst_mem_ie", mem_ie, 1);
        check("pre_rst_addr", mem_address, 1);
        #1 rst = 1'b0;
        #1;
        check("arst_mem_ie", mem_ie, 0);
        check("arst_ready", in_ready, 0);
        check("arst_halt", cpu_halt, 0);
        check("arst_count", count, 0);
        check("arst_addr", mem_address, 0);
        check("arst_done", done, 0);
        check("arst_error", error, 0);
        @(negedge clk);
        #1;
        check("arst_mem0", mem[0], 8'h99);
        check("arst_mem1", mem[1], 8'h01 ^ 8'h5A);
        rst = 1'b1;
        step();
        check("post_rst_ready", in_ready, 0);

        // start together with in_valid in IDLE arms only
        fill_mem();
        start    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h11;
        in_last  = 1'b1;
        step();
        start = 1'b0;
        check("co_start_mem_ie", mem_ie, 0);
        check("co_start_count", count, 0);
        check("co_start_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        check("co_wr_mem_ie", mem_ie, 1);
        check("co_wr_bus", bus, 8'h11);
        check("co_wr_addr", mem_address, 0);
        step();
        check("co_done", done, 1);
        check("co_count", count, 1);
        check("co_halt", cpu_halt, 0);
        check("co_mem0", mem[0], 8'h11);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
